// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, held until imem_ready
//   imem_addr  : byte address of the requested word, held until imem_ready
//   imem_ready : response strobe; imem_rdata is valid when high together with imem_req
//   imem_rdata : instruction word
// master = fetch side, slave = memory side.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding decode.
// Holds the PC, issues word fetches over the imem bus, and presents each fetched
// instruction in a registered slot {instruction, pc_out, DecodeEnable}. A one-entry skid
// buffer absorbs a response that lands while decode is stalled. Redirects flush the slot
// and skid and restart fetch at redirect_pc; halt stops fetching until reset.
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   imem                  : instruction-memory bus (master side)
//   instruction, pc_out   : presented instruction and its address (registered)
//   DecodeEnable          : presented instruction valid (registered)
//   decode_stall          : decode cannot accept; hold the slot
//   redirect, redirect_pc : control-flow change and its target
//   halt, halted          : stop request and halted status
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic                clk,
  input  logic                reset,
  fetch_stage_if.master       imem,
  output logic [31:0]         instruction,
  output logic                DecodeEnable,
  output logic [31:0]         pc_out,
  input  logic                decode_stall,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                halt,
  output logic                halted
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StSkid = 2'd2;
  localparam logic [1:0] StHalt = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        dec_en_q, dec_en_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        drop_q, drop_d;           // outstanding response must be discarded
  logic [31:0] drop_addr_q, drop_addr_d; // address still shown on the bus while dropping
  logic        halt_pend_q, halt_pend_d; // halt seen mid-handshake

  logic consume;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc_out_d     = pc_out_q;
    dec_en_d     = dec_en_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    drop_d       = drop_q;
    drop_addr_d  = drop_addr_q;
    halt_pend_d  = halt_pend_q;

    consume = dec_en_q & ~decode_stall;
    if (consume) dec_en_d = 1'b0;

    case (state_q)
      StIdle: begin
        // Skid is always empty here, so can_issue reduces to no halt and no held slot.
        if (halt) begin
          state_d = StHalt;
        end else if (redirect) begin
          dec_en_d     = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = redirect_pc;
        end else if (!(dec_en_q && decode_stall)) begin
          state_d = StReq;
        end
      end

      StReq: begin
        halt_pend_d = halt_pend_q | halt;
        if (redirect) begin
          dec_en_d     = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = redirect_pc;
        end
        if (imem.imem_ready) begin
          drop_d = 1'b0;
          if (halt_pend_d) begin
            halt_pend_d = 1'b0;
            state_d     = StHalt;
          end else if (redirect || drop_q) begin
            // Response belongs to the old path; slot was flushed so fetch can go on.
            state_d = StReq;
          end else begin
            pc_d = pc_q + PC_STEP;
            if (!dec_en_q || consume) begin
              instr_d  = imem.imem_rdata;
              pc_out_d = pc_q;
              dec_en_d = 1'b1;
              state_d  = decode_stall ? StIdle : StReq;
            end else begin
              skid_instr_d = imem.imem_rdata;
              skid_pc_d    = pc_q;
              skid_valid_d = 1'b1;
              state_d      = StSkid;
            end
          end
        end else if (redirect) begin
          // Keep the bus stable on the old address until its response retires.
          if (!drop_q) drop_addr_d = pc_q;
          drop_d = 1'b1;
        end
      end

      StSkid: begin
        if (halt) begin
          skid_valid_d = 1'b0;
          state_d      = StHalt;
        end else if (redirect) begin
          dec_en_d     = 1'b0;
          skid_valid_d = 1'b0;
          pc_d         = redirect_pc;
          state_d      = StIdle;
        end else if (consume) begin
          instr_d      = skid_instr_q;
          pc_out_d     = skid_pc_q;
          dec_en_d     = 1'b1;
          skid_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end

      default: ; // StHalt: absorbing, only the slot drains
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      pc_out_q     <= '0;
      dec_en_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      drop_q       <= 1'b0;
      drop_addr_q  <= '0;
      halt_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc_out_q     <= pc_out_d;
      dec_en_q     <= dec_en_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      drop_q       <= drop_d;
      drop_addr_q  <= drop_addr_d;
      halt_pend_q  <= halt_pend_d;
    end
  end

  assign imem.imem_req  = (state_q == StReq);
  assign imem.imem_addr = drop_q ? drop_addr_q : pc_q;
  assign instruction    = instr_q;
  assign DecodeEnable   = dec_en_q;
  assign pc_out         = pc_out_q;
  assign halted         = (state_q == StHalt);

endmodule
